fire_zone_alarm: RTL and testbench
==================================

// Module: fire_zone_alarm
// PURPOSE
//  Multi-zone successor to the single-sensor fire block in the smart-home controller.
//  Debounces ZONES raw fire sensors. Latches which zones confirmed a fire.
//  Drives one alarm output, with an acknowledge/silence timer and an explicit clear.
//  Sits between the house sensor inputs and the buzzer/notification logic.
// PARAMETERS
//  ZONES        4   number of independent fire-sensor zones (>=1)
//  CONFIRM_CYC  4   consecutive high samples needed to confirm a zone (>=1)
//  SILENCE_CYC  16  cycles the alarm stays silenced after ack (>=1)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      synchronous, active-high reset
//  f_sensor  in   ZONES  raw fire sensor per zone, 1 = fire detected
//  ack       in   1      silence request (1-cycle pulse or level)
//  clear     in   1      operator clear/re-arm request
//  f_alarm   out  1      alarm sounder, 1 = sounding
//  f_zone    out  ZONES  sticky per-zone confirmed-fire flags
//  state     out  2      0 IDLE, 1 PRE, 2 ALARM, 3 SILENCED
//  silenced  out  1      1 while state==SILENCED
// BEHAVIOUR
//  Reset:
//   - rst=1 at an edge sets state=IDLE, f_alarm=0, f_zone=0, silenced=0.
//   - All zone counters and the silence timer go to 0. rst overrides every other input.
//  Debounce, per zone i:
//   - cnt[i] (width $clog2(CONFIRM_CYC+1)) increments while f_sensor[i]=1, saturating at CONFIRM_CYC.
//   - cnt[i] goes to 0 on any sample with f_sensor[i]=0.
//   - conf[i] = f_sensor[i] & (cnt[i]==CONFIRM_CYC-1); it fires on the CONFIRM_CYC-th consecutive high edge.
//   - new[i] = conf[i] & ~f_zone[i]. f_zone[i] is set at that edge.
//   - With CONFIRM_CYC=1, a single high sample confirms.
//   - Counters run in every state. f_zone bits clear only on rst or a clear->IDLE transition.
//  FSM, evaluated once per edge; conditions are listed in priority order:
//   IDLE:     |new -> ALARM; else |f_sensor -> PRE; else stay.
//   PRE:      |new -> ALARM; else ~|f_sensor -> IDLE; else stay.
//   ALARM:    clear & ~|f_sensor -> IDLE, f_zone<=0; else ack -> SILENCED, timer<=SILENCE_CYC; else stay.
//   SILENCED:
//     - clear & ~|f_sensor -> IDLE, f_zone<=0.
//     - else |new -> ALARM (a newly confirmed zone overrides silence).
//     - else ack -> stay, timer<=SILENCE_CYC (reload).
//     - else timer==1 & |f_sensor -> ALARM, timer<=0.
//     - else timer==1 -> stay, timer<=0 (waits for clear).
//     - else timer<=timer-(timer!=0).
//  Ignored inputs:
//   - ack and clear are ignored in IDLE and PRE.
//   - clear is ignored while any f_sensor bit is high.
//   - In ALARM, if ack and new arrive on the same edge, ack wins; the new zone is still latched in f_zone.
//  Outputs are registered, with no combinational path from input to output:
//   - f_alarm = (next state == ALARM). It rises on the same edge the first zone confirms.
//   - silenced = (next state == SILENCED). state reflects the registered FSM state.
//  Silence duration: ack at edge k gives f_alarm=0 for edges k..k+SILENCE_CYC-1 (exactly SILENCE_CYC cycles).
//   - If any sensor is still high, f_alarm=1 again after edge k+SILENCE_CYC.
// TESTING  (ZONES=4, CONFIRM_CYC=4, SILENCE_CYC=16)
//  1. Hold rst=1 for 2 edges with f_sensor=4'b1111.
//     -> f_alarm=0, f_zone=0, state=0, silenced=0.
//  2. f_sensor=4'b0010 for 3 edges, then 0.
//     -> state goes 1 then back to 0; f_alarm stays 0; f_zone=0.
//  3. f_sensor=4'b0100 held.
//     -> after the 4th high edge: f_alarm=1, f_zone=4'b0100, state=2.
//  4. From test 3, pulse ack with sensor still high.
//     -> f_alarm=0, silenced=1 for exactly 16 cycles; then f_alarm=1, state=2.
//  5. In SILENCED, additionally raise f_sensor[0] for 4 edges.
//     -> f_alarm=1 right after its 4th edge; f_zone=4'b0101; timer abandoned.
//  6. clear while any sensor high -> no change. Drop all sensors, pulse clear.
//     -> state=0, f_zone=0, f_alarm=0.
//     Also: rst mid-ALARM -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/fire_zone_alarm.sv
// Multi-zone fire alarm block.
// Debounces ZONES raw fire sensors and latches every zone that confirms a fire.
// Drives one alarm sounder, with an acknowledge/silence timer and an operator clear.
module fire_zone_alarm #(
    parameter int ZONES       = 4,
    parameter int CONFIRM_CYC = 4,
    parameter int SILENCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ZONES-1:0] f_sensor,
    input  logic             ack,
    input  logic             clear,
    output logic             f_alarm,
    output logic [ZONES-1:0] f_zone,
    output logic [1:0]       state,
    output logic             silenced
);

    localparam int CW = $clog2(CONFIRM_CYC + 1);
    localparam int TW = $clog2(SILENCE_CYC + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CONFIRM_CYC);
    localparam logic [CW-1:0] CNT_HIT  = CW'(CONFIRM_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(SILENCE_CYC);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRE      = 2'd1,
        ST_ALARM    = 2'd2,
        ST_SILENCED = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ZONES-1:0] zone_d;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    logic [CW-1:0]    cnt [ZONES];
    logic [ZONES-1:0] conf;
    logic [ZONES-1:0] new_zone;
    logic             any_new;
    logic             any_fire;

    // Per-zone debounce counters: count consecutive high samples, saturate, restart on any low sample.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= so every register samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < ZONES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                if (!f_sensor[i])
                    cnt[i] <= '0;
                else if (cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    // A zone confirms on its CONFIRM_CYC-th consecutive high sample; only not-yet-latched zones count as new.
    always_comb begin
        for (int i = 0; i < ZONES; i++)
            conf[i] = f_sensor[i] && (cnt[i] == CNT_HIT);
        new_zone = conf & ~f_zone;
        any_new  = |new_zone;
        any_fire = |f_sensor;
    end

    // Next-state, zone-latch and silence-timer logic, conditions in priority order.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        zone_d  = f_zone | new_zone;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (any_new)       state_d = ST_ALARM;
                else if (any_fire) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (any_new)        state_d = ST_ALARM;
                else if (!any_fire) state_d = ST_IDLE;
            end
            ST_ALARM: begin
                if (clear && !any_fire) begin
                    state_d = ST_IDLE;
                    zone_d  = '0;
                end else if (ack) begin
                    // ack beats a same-edge new zone; that zone is still latched via the default.
                    state_d = ST_SILENCED;
                    timer_d = TMR_LOAD;
                end
            end
            ST_SILENCED: begin
                if (clear && !any_fire) begin
                    state_d = ST_IDLE;
                    zone_d  = '0;
                    timer_d = '0;
                end else if (any_new) begin
                    state_d = ST_ALARM;
                    timer_d = '0;
                end else if (ack) begin
                    timer_d = TMR_LOAD;
                end else if (timer_q == TMR_ONE) begin
                    // Expiry re-arms the sounder only while a sensor is still active;
                    // otherwise stay silenced with the timer parked at 0 until clear.
                    timer_d = '0;
                    if (any_fire) state_d = ST_ALARM;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, zone flags, timer and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            f_zone   <= '0;
            f_alarm  <= 1'b0;
            silenced <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            f_zone   <= zone_d;
            f_alarm  <= (state_d == ST_ALARM);
            silenced <= (state_d == ST_SILENCED);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fire_zone_alarm.sv
// Directed testbench for fire_zone_alarm (ZONES=4, CONFIRM_CYC=4, SILENCE_CYC=16).
// Observations are packed as {f_alarm, silenced, state[1:0], f_zone[3:0]}.
module tb_fire_zone_alarm;

    logic       clk;
    logic       rst;
    logic [3:0] f_sensor;
    logic       ack;
    logic       clear;
    logic       f_alarm;
    logic [3:0] f_zone;
    logic [1:0] state;
    logic       silenced;

    int errors = 0;
    int checks = 0;

    fire_zone_alarm #(
        .ZONES       (4),
        .CONFIRM_CYC (4),
        .SILENCE_CYC (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_sensor (f_sensor),
        .ack      (ack),
        .clear    (clear),
        .f_alarm  (f_alarm),
        .f_zone   (f_zone),
        .state    (state),
        .silenced (silenced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {f_alarm, silenced, state, f_zone};
    endfunction

    function automatic logic [7:0] exp_v(input logic a, input logic s, input logic [1:0] st,
                                         input logic [3:0] z);
        return {a, s, st, z};
    endfunction

    task automatic do_reset();
        rst = 1'b1; f_sensor = '0; ack = 1'b0; clear = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Zone 2 held high until it confirms; leaves the DUT in ALARM with f_zone=0100.
    task automatic go_alarm_zone2();
        f_sensor = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1; f_sensor = 4'b1111; ack = 1'b1; clear = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_edge%0d got=%b want=%b", i, obs(), e);
            end
        end
        rst = 1'b0; f_sensor = '0; ack = 1'b0;
    endtask

    task automatic test_glitch();
        logic [7:0] e;
        do_reset();
        // Two short bursts of 3 highs separated by a low never confirm.
        for (int burst = 0; burst < 2; burst++) begin
            f_sensor = 4'b0010;
            e = exp_v(1'b0, 1'b0, 2'd1, 4'b0000);
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL glitch_pre b%0d e%0d got=%b want=%b", burst, i, obs(), e);
                end
            end
            f_sensor = 4'b0000;
            tick();
            e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL glitch_idle b%0d got=%b want=%b", burst, obs(), e);
            end
        end
    endtask

    task automatic test_confirm();
        logic [7:0] e;
        do_reset();
        f_sensor = 4'b0100;
        e = exp_v(1'b0, 1'b0, 2'd1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL confirm_pre e%0d got=%b want=%b", i, obs(), e);
            end
        end
        tick();
        e = exp_v(1'b1, 1'b0, 2'd2, 4'b0100);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL confirm_alarm got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_silence();
        logic [7:0] e;
        do_reset();
        go_alarm_zone2();
        ack = 1'b1;
        e = exp_v(1'b0, 1'b1, 2'd3, 4'b0100);
        for (int i = 0; i < 16; i++) begin
            tick();
            ack = 1'b0;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL silence_hold e%0d got=%b want=%b", i, obs(), e);
            end
        end
        tick();
        e = exp_v(1'b1, 1'b0, 2'd2, 4'b0100);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL silence_expire got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_new_zone_override();
        logic [7:0] e;
        do_reset();
        go_alarm_zone2();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        f_sensor = 4'b0101;
        e = exp_v(1'b0, 1'b1, 2'd3, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL override_wait e%0d got=%b want=%b", i, obs(), e);
            end
        end
        tick();
        e = exp_v(1'b1, 1'b0, 2'd2, 4'b0101);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL override_alarm got=%b want=%b", obs(), e);
        end
        // Clear is ignored while sensors are high.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL clear_ignored got=%b want=%b", obs(), e);
        end
        f_sensor = 4'b0000;
        tick();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL alarm_holds_no_sensor got=%b want=%b", obs(), e);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL clear_idle got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_expire_no_sensor();
        logic [7:0] e;
        do_reset();
        go_alarm_zone2();
        f_sensor = 4'b0000;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        e = exp_v(1'b0, 1'b1, 2'd3, 4'b0100);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL expire_waits got=%b want=%b", obs(), e);
        end
        // Sensor back on, already latched zone: no new, clear ignored, stays silenced.
        f_sensor = 4'b0100;
        clear = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL silenced_clear_ignored got=%b want=%b", obs(), e);
        end
        f_sensor = 4'b0000;
        tick();
        clear = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL silenced_clear got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_ignored_in_idle();
        logic [7:0] e;
        do_reset();
        ack = 1'b1; clear = 1'b1;
        tick();
        ack = 1'b0; clear = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL idle_ack_ignored got=%b want=%b", obs(), e);
        end
        f_sensor = 4'b0001;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd1, 4'b0000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL pre_ack_ignored got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        do_reset();
        go_alarm_zone2();
        f_sensor = 4'b0101;
        for (int i = 0; i < 3; i++) tick();
        e = exp_v(1'b1, 1'b0, 2'd2, 4'b0100);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL b2b_pre_ack got=%b want=%b", obs(), e);
        end
        // ack on the same edge zone 0 confirms: ack wins, zone still latched.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = exp_v(1'b0, 1'b1, 2'd3, 4'b0101);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL ack_beats_new got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_rst_mid_alarm();
        logic [7:0] e;
        do_reset();
        f_sensor = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        e = exp_v(1'b1, 1'b0, 2'd2, 4'b1000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rst_pre_alarm got=%b want=%b", obs(), e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = exp_v(1'b0, 1'b0, 2'd0, 4'b0000);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rst_mid_alarm got=%b want=%b", obs(), e);
        end
        f_sensor = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; f_sensor = '0; ack = 1'b0; clear = 1'b0;
        test_reset();
        test_glitch();
        test_confirm();
        test_silence();
        test_new_zone_override();
        test_expire_no_sensor();
        test_ignored_in_idle();
        test_back_to_back();
        test_rst_mid_alarm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
